// File: rtl/debounce_sync.sv
// debounce_sync: synchronizer chain + two-state settling FSM that turns a bouncy
// asynchronous input into a clean level with one-cycle edge pulses. Optional
// aborted-settle counter on port glitch_cnt is compiled in with DEBOUNCE_GLITCH_CNT_EN.
module debounce_sync #(
    parameter int SYNC_STAGES  = 2,
    parameter int STABLE_COUNT = 1000,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din_async,
    output logic       dout,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic       busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("debounce_sync: SYNC_STAGES must be at least 2");
        end
        if (STABLE_COUNT < 2) begin : g_bad_count
            $error("debounce_sync: STABLE_COUNT must be at least 2");
        end
        if ((64'd1 << CNT_W) <= 64'(STABLE_COUNT)) begin : g_bad_width
            $error("debounce_sync: CNT_W too narrow for STABLE_COUNT");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_dout;
    logic                   r_rise;
    logic                   r_fall;

    logic                   w_s;
    logic                   w_diff;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_dout_nxt;
    logic                   w_rise_nxt;
    logic                   w_fall_nxt;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic                   w_glitch;
    logic [7:0]             r_glitch_cnt;
`endif

    // Metastability filter: shift the raw input through SYNC_STAGES flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= {SYNC_STAGES{1'b0}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din_async};
        end
    end

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_diff = w_s ^ r_dout;

    // Settling FSM: next state, stability counter, debounced level and pulses.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dout_nxt  = r_dout;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
        w_glitch    = 1'b0;
`endif
        case (r_state)
            ST_STABLE: begin
                if (w_diff) begin
                    w_state_nxt = ST_SETTLING;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = CNT_ZERO;
                end
            end
            ST_SETTLING: begin
                if (w_diff) begin
                    if (r_cnt >= CNT_LAST) begin
                        // Counter saturates at the threshold; reaching it commits the toggle.
                        w_dout_nxt  = ~r_dout;
                        w_rise_nxt  = ~r_dout;
                        w_fall_nxt  = r_dout;
                        w_cnt_nxt   = CNT_ZERO;
                        w_state_nxt = ST_STABLE;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_ONE;
                        w_state_nxt = ST_SETTLING;
                    end
                end else begin
                    w_cnt_nxt   = CNT_ZERO;
                    w_state_nxt = ST_STABLE;
`ifdef DEBOUNCE_GLITCH_CNT_EN
                    w_glitch    = 1'b1;
`endif
                end
            end
            default: begin
                w_state_nxt = ST_STABLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // FSM state, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_STABLE;
            r_cnt   <= CNT_ZERO;
            r_dout  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dout  <= w_dout_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

`ifdef DEBOUNCE_GLITCH_CNT_EN
    // Aborted-settle counter, saturating at 255.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_glitch_cnt <= 8'd0;
        end else if (w_glitch && (r_glitch_cnt != 8'hFF)) begin
            r_glitch_cnt <= r_glitch_cnt + 8'd1;
        end else begin
            r_glitch_cnt <= r_glitch_cnt;
        end
    end

    assign glitch_cnt = r_glitch_cnt;
`endif

    assign dout       = r_dout;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
    assign busy       = (r_state == ST_SETTLING);

endmodule

// File: tb/tb_debounce_sync.sv
// Directed self-checking bench for debounce_sync with SYNC_STAGES=2, STABLE_COUNT=4.
// Edge numbers in the tables count from the first edge that samples a new input.
module tb_debounce_sync;

    logic       clk;
    logic       reset;
    logic       din_async;
    logic       dout;
    logic       rise_pulse;
    logic       fall_pulse;
    logic       busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    int n_checks;
    int n_errors;
    int n_fall;

    debounce_sync #(
        .SYNC_STAGES (2),
        .STABLE_COUNT(4),
        .CNT_W       (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din_async (din_async),
        .dout      (dout),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .busy      (busy)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt(glitch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        n_fall    = 0;
        reset     = 1'b1;
        din_async = 1'b1;

        // Reset with din high
        tick(2);
        check_eq("rst_dout", 32'(dout), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rise", 32'(rise_pulse), 32'd0);
        check_eq("rst_fall", 32'(fall_pulse), 32'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check_eq("rst_glitch", 32'(glitch_cnt), 32'd0);
`endif
        reset = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick(1);
            check_eq("post_rst_dout", 32'(dout), 32'(e >= 6));
            check_eq("post_rst_rise", 32'(rise_pulse), 32'(e == 6));
            check_eq("post_rst_busy", 32'(busy), 32'(e >= 3 && e <= 5));
        end

        // Clean fall
        din_async = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick(1);
            check_eq("fall_busy", 32'(busy), 32'(e >= 3 && e <= 5));
            check_eq("fall_dout", 32'(dout), 32'(e < 6));
            check_eq("fall_pulse", 32'(fall_pulse), 32'(e == 6));
            check_eq("fall_rise", 32'(rise_pulse), 32'd0);
        end

        // Bounce: toggle every 2 cycles for 20 cycles, then hold 1
        for (int i = 0; i < 20; i++) begin
            din_async = ((i / 2) % 2 == 0) ? 1'b1 : 1'b0;
            tick(1);
            check_eq("bounce_dout", 32'(dout), 32'd0);
            check_eq("bounce_rise", 32'(rise_pulse), 32'd0);
        end
        din_async = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick(1);
            check_eq("bounce_end_dout", 32'(dout), 32'(e >= 6));
            check_eq("bounce_end_rise", 32'(rise_pulse), 32'(e == 6));
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check_eq("bounce_glitch", 32'(glitch_cnt), 32'd5);
`endif

        // Reset mid-settle
        din_async = 1'b0;
        tick(8);
        check_eq("pre_mid_dout", 32'(dout), 32'd0);
        din_async = 1'b1;
        tick(3);
        check_eq("mid_busy_e3", 32'(busy), 32'd1);
        reset = 1'b1;
        tick(1);
        check_eq("mid_rst_dout", 32'(dout), 32'd0);
        check_eq("mid_rst_rise", 32'(rise_pulse), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_cnt", 32'(dut.r_cnt), 32'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check_eq("mid_rst_glitch", 32'(glitch_cnt), 32'd0);
`endif
        reset = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick(1);
            check_eq("restart_dout", 32'(dout), 32'(e >= 6));
            check_eq("restart_rise", 32'(rise_pulse), 32'(e == 6));
        end

        // 300 single-sample low glitches while dout is high
        for (int k = 0; k < 300; k++) begin
            din_async = 1'b0;
            tick(1);
            n_fall += int'(fall_pulse);
            din_async = 1'b1;
            tick(1);
            n_fall += int'(fall_pulse);
        end
        tick(4);
        check_eq("sat_no_fall", 32'(n_fall), 32'd0);
        check_eq("sat_dout", 32'(dout), 32'd1);
        check_eq("sat_busy", 32'(busy), 32'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check_eq("sat_glitch", 32'(glitch_cnt), 32'd255);
`endif

        // Revert exactly at threshold: low for 3 samples only
        for (int e = 1; e <= 8; e++) begin
            din_async = (e <= 3) ? 1'b0 : 1'b1;
            tick(1);
            check_eq("thr_dout", 32'(dout), 32'd1);
            check_eq("thr_fall", 32'(fall_pulse), 32'd0);
            check_eq("thr_busy", 32'(busy), 32'(e >= 3 && e <= 5));
        end

        // Back-to-back: fall then immediate new rise settle
        for (int e = 1; e <= 11; e++) begin
            din_async = (e <= 4) ? 1'b0 : 1'b1;
            tick(1);
            check_eq("b2b_dout", 32'(dout), 32'(e < 6 || e >= 10));
            check_eq("b2b_fall", 32'(fall_pulse), 32'(e == 6));
            check_eq("b2b_rise", 32'(rise_pulse), 32'(e == 10));
            check_eq("b2b_busy", 32'(busy), 32'((e >= 3 && e <= 5) || (e >= 7 && e <= 9)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
